// File: rtl/norm_scaler_pipe_pkg.sv
// Shared types and helpers for the pixel normaliser: FSM state encoding,
// coefficient width and the round-and-saturate step of the output stage.
package norm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIV     = 3'd1,
    WAIT_UP = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4
  } norm_state_e;

  // Coefficient carries the full output range plus the fractional bits.
  function automatic int coef_w(input int out_w, input int frac_w);
    return out_w + frac_w;
  endfunction

  // Round half-up by adding 0.5 LSB before dropping the fraction, then clamp
  // to full scale of the output width.
  function automatic logic [63:0] sat_round(input logic [63:0] prod,
                                            input int frac_w,
                                            input int out_w);
    logic [63:0] rounded;
    logic [63:0] full_scale;
    rounded    = (prod + (64'd1 << (frac_w - 1))) >> frac_w;
    full_scale = (64'd1 << out_w) - 64'd1;
    return (rounded > full_scale) ? full_scale : rounded;
  endfunction

endpackage

// File: rtl/norm_scaler_pipe_if.sv
// AXI-Stream style beat bus used for both the pixel input and the normalised output.
// A beat transfers on a rising clk edge where tvalid && tready; the master holds
// tdata/tlast stable while tvalid && !tready, and never waits on tready to raise tvalid.
interface norm_axis_if #(
  parameter int W = 10
) ();

  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/norm_scaler_pipe_udiv_seq.sv
// Sequential restoring divider: one quotient bit per cycle, N_W cycles per divide.
// o_done pulses in the final iteration cycle with the completed quotient on o_quot.
module udiv_seq #(
  parameter int N_W = 20,
  parameter int D_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic [N_W-1:0] i_num,
  input  logic [D_W-1:0] i_den,
  output logic           o_busy,
  output logic           o_done,
  output logic [N_W-1:0] o_quot
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_W - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [N_W-1:0]   r_num;
  logic [D_W-1:0]   r_den;
  logic [D_W-1:0]   r_rem;
  logic [N_W-1:0]   r_quot;

  logic [D_W:0]     w_trial;
  logic [D_W:0]     w_diff;
  logic             w_ge;
  logic [D_W-1:0]   w_rem_nxt;
  logic [N_W-1:0]   w_quot_nxt;

  // Partial remainder is always below the divisor, so the shifted trial value
  // needs exactly one extra bit and the restored remainder fits back in D_W.
  assign w_trial    = {r_rem, r_num[N_W-1]};
  assign w_diff     = w_trial - {1'b0, r_den};
  assign w_ge       = (w_trial >= {1'b0, r_den});
  assign w_rem_nxt  = D_W'(w_ge ? w_diff : w_trial);
  assign w_quot_nxt = {r_quot[N_W-2:0], w_ge};

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == LAST_ITER);
  assign o_quot = w_quot_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_num  <= '0;
      r_den  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_num  <= i_num;
      r_den  <= i_den;
      r_rem  <= '0;
      r_quot <= '0;
    end else if (r_busy) begin
      r_num  <= r_num << 1;
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == LAST_ITER) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/norm_scaler_pipe.sv
// Per-frame pixel normaliser: derives a fixed-point reciprocal coefficient from the
// latched denominator, then scales exactly one frame of pixels through a 2-stage pipe.
module norm_scaler_pipe
  import norm_pkg::*;
#(
  parameter int PIXEL_W = 10,
  parameter int OUT_W   = 10,
  parameter int FRAC_W  = 10,
  parameter int ROWS    = 10,
  parameter int COLS    = 10
) (
  input  logic               clk,
  input  logic               s_axis_resetn,
  input  logic               ap_start,
  input  logic               seq_ap_idle,
  input  logic               cf_ap_done,
  output logic               ap_ready,
  output logic               ap_idle,
  output logic               ap_done,
  input  logic [PIXEL_W-1:0] norm_denominator,
  output logic               div_by_zero,
  norm_axis_if.slave         s_axis,
  norm_axis_if.master        m_axis,
  output norm_state_e        o_dbg_state
);

  localparam int COEF_W    = coef_w(OUT_W, FRAC_W);
  localparam int PROD_W    = PIXEL_W + COEF_W;
  localparam int FRAME_PIX = ROWS * COLS;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);

  localparam logic [COEF_W-1:0] DIV_NUM   = COEF_W'(((64'd1 << OUT_W) - 64'd1) << FRAC_W);
  localparam logic [COEF_W-1:0] COEF_ONE  = COEF_W'(64'd1 << FRAC_W);
  localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_PIX);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_PIX - 1);

  norm_state_e       r_state;
  norm_state_e       w_state_nxt;

  logic              r_dbz;
  logic              r_cf_seen;
  logic [COEF_W-1:0] r_coef;
  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  r_out_cnt;

  logic              r_v1;
  logic [PROD_W-1:0] r_prod;
  logic              r_v2;
  logic [OUT_W-1:0]  r_data;

  logic              w_accept;
  logic              w_adv;
  logic              w_s_hs;
  logic              w_m_hs;
  logic              w_last_beat;
  logic              w_s_tready;
  logic              w_div_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [COEF_W-1:0] w_div_quot;
  logic              w_unused;

  // ---------------------------------------------------------------- divider
  // A zero denominator never reaches the divider; the FSM substitutes unity gain.
  assign w_div_start = w_accept && (norm_denominator != '0);

  udiv_seq #(
    .N_W (COEF_W),
    .D_W (PIXEL_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (s_axis_resetn),
    .i_start (w_div_start),
    .i_num   (DIV_NUM),
    .i_den   (norm_denominator),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quot  (w_div_quot)
  );

  // ------------------------------------------------------------- handshakes
  assign w_accept    = (r_state == IDLE) && ap_start && seq_ap_idle;
  assign w_adv       = !r_v2 || m_axis.tready;
  assign w_s_hs      = s_axis.tvalid && w_s_tready;
  assign w_m_hs      = r_v2 && m_axis.tready;
  assign w_last_beat = w_m_hs && (r_out_cnt == LAST_CNT);

  assign w_unused    = ^{s_axis.tlast, w_div_busy};

  // ---------------------------------------------------------- FSM: state reg
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------- FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)                     w_state_nxt = DIV;
      DIV:     if (r_dbz || w_div_done)          w_state_nxt = WAIT_UP;
      WAIT_UP: if (r_cf_seen || cf_ap_done)      w_state_nxt = STREAM;
      STREAM:  if (r_in_cnt == FRAME_CNT)        w_state_nxt = DRAIN;
      DRAIN:   if (w_last_beat)                  w_state_nxt = IDLE;
      default:                                   w_state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------ FSM: outputs
  // Input ready follows the output side combinationally so a full pipe still
  // streams one pixel per cycle while the consumer keeps up.
  always_comb begin
    ap_ready   = (r_state == IDLE);
    ap_idle    = (r_state == IDLE);
    ap_done    = (r_state == DRAIN) && w_last_beat;
    w_s_tready = (r_state == STREAM) && w_adv && (r_in_cnt < FRAME_CNT);
  end

  assign s_axis.tready = w_s_tready;
  assign o_dbg_state   = r_state;
  assign div_by_zero   = r_dbz;

  // ------------------------------------------------ frame control registers
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      r_dbz     <= 1'b0;
      r_cf_seen <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_accept) begin
      r_dbz     <= (norm_denominator == '0);
      r_cf_seen <= 1'b0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (cf_ap_done && (r_state != IDLE)) begin
        r_cf_seen <= 1'b1;
      end
      if (w_s_hs) begin
        r_in_cnt <= r_in_cnt + CNT_W'(1);
      end
      if (w_m_hs) begin
        r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      r_coef <= '0;
    end else if ((r_state == DIV) && r_dbz) begin
      r_coef <= COEF_ONE;
    end else if ((r_state == DIV) && w_div_done) begin
      r_coef <= w_div_quot;
    end
  end

  // ---------------------------------------------------------------- datapath
  // Both stages move together on w_adv; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_v2   <= 1'b0;
      r_data <= '0;
    end else if (w_adv) begin
      r_v1 <= w_s_hs;
      if (w_s_hs) begin
        r_prod <= PROD_W'(s_axis.tdata) * PROD_W'(r_coef);
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_data <= OUT_W'(sat_round(64'(r_prod), FRAC_W, OUT_W));
      end
    end
  end

  assign m_axis.tvalid = r_v2;
  assign m_axis.tdata  = r_data;
  assign m_axis.tlast  = r_v2 && (r_out_cnt == LAST_CNT);

endmodule
